rx_stream_loader: RTL and testbench
===================================

// Module: rx_stream_loader
// PURPOSE
//  Receive-side front end between the MAC Avalon-ST source and the input FIFO.
//  Accepts packet beats, writes packet words into the input FIFO and tracks length.
//  Enforces packet framing and drops malformed or oversize packets.
//  Generates the ready/eop/error pulses consumed by the sniffer controller.
// PARAMETERS
//  DATA_W     32    beat/FIFO word width in bits (multiple of 8)
//  LEN_W      12    pkt_len width in bytes
//  MAX_BYTES  1518  largest legal packet; larger is treated as error
// PORTS
//  clk         in   1       clock
//  n_rst       in   1       reset, asynchronous, active-low
//  st_valid    in   1       MAC beat valid
//  st_data     in   DATA_W  MAC beat data
//  st_sop      in   1       first beat of packet
//  st_eop      in   1       last beat of packet
//  st_error    in   1       MAC error flag for this beat
//  st_empty    in   2       unused bytes in eop beat (0..DATA_W/8-1)
//  st_ready    out  1       beat accept; beat taken when st_valid & st_ready
//  fifo_wrfull in   1       input FIFO full
//  fifo_wrreq  out  1       input FIFO write strobe
//  fifo_data   out  DATA_W  input FIFO write data
//  pkt_ready   out  1       1-cycle pulse: new packet started (controller ready)
//  pkt_eop     out  1       1-cycle pulse: packet ended (controller eop)
//  pkt_error   out  1       1-cycle pulse: packet bad (controller error)
//  pkt_len     out  LEN_W   byte count of last packet; valid from pkt_eop
//  drop_count  out  16      saturating count of dropped packets
// BEHAVIOUR
//  Reset: state IDLE; pkt_ready/pkt_eop/pkt_error 0, pkt_len 0, drop_count 0, gap counter 0.
//  Reset mid-packet: packet abandoned; no pulses emitted; next beat must carry sop.
//  States: IDLE, RECV, DROP.
//  st_ready: 0 during gap cycles; 1 in DROP; otherwise !fifo_wrfull.
//  Write path (combinational, zero latency):
//  - fifo_wrreq = accept & writing beat; fifo_data = st_data.
//  - Never write while fifo_wrfull.
//  Pulses are registered: asserted the cycle after the triggering accept.
//  IDLE:
//  - sop beat -> write, pkt_ready, len = beat bytes, go RECV.
//  - Non-sop beat accepted and discarded (not counted).
//  - sop+eop beat: pkt_ready at N+1, pkt_eop at N+2 (eop deferred), back to IDLE.
//  RECV, each beat written and len += beat bytes:
//  - Beat bytes: DATA_W/8, or DATA_W/8 - st_empty on eop beat.
//  - eop beat -> pkt_eop, pkt_len updated, IDLE.
//  - st_error, len > MAX_BYTES, or sop -> offending beat NOT written, pkt_error, drop_count+1.
//    Then if that beat had eop: pkt_eop one cycle after pkt_error, IDLE; else DROP.
//  DROP: beats accepted and discarded; eop beat -> pkt_eop, IDLE.
//  Pulse ordering: pkt_ready, pkt_eop and pkt_error never coincide.
//  Gap: after any eop accept, st_ready forced low 1 cycle (2 if eop deferred),
//  so pulses of consecutive packets never collide.
//  len arithmetic in LEN_W+1 bits; oversize check before write; drop_count saturates at 16'hFFFF.
// CONFIGURATION
//  RX_STATS_EN defined: drop_count counts as above.
//  RX_STATS_EN undefined: drop_count tied to 0, counter logic removed; all else identical.
// TESTING
//  3 beats, empty=2 on last -> 3 wrreq in accept cycles, pkt_ready @acc1+1, pkt_eop @acc3+1, pkt_len=10.
//  Single beat sop+eop, empty=0 -> pkt_ready @N+1, pkt_eop @N+2, pkt_len=4, st_ready low N+1..N+2.
//  5 beats, st_error on beat 2 -> 1 wrreq, pkt_error @acc2+1, pkt_eop @acc5+1, drop_count=1.
//  fifo_wrfull high 3 cycles mid-packet -> st_ready=0, no wrreq, all words written in order afterwards.
//  380 full beats, MAX_BYTES=1518 -> beat 380 (1520 B) not written, pkt_error, DROP until eop.
//  sop mid-packet, then n_rst low mid-packet -> pkt_error + drop_count+1; after reset all outputs 0, IDLE.

Source files
------------

// File: rtl/rx_stream_loader.sv
// rx_stream_loader
//   Receive-side front end between the MAC Avalon-ST source and the input FIFO.
//   Good packet beats go straight to the FIFO with zero latency. The block
//   tracks the byte length of each packet and drops malformed or oversize
//   packets. It also produces the one-cycle ready/eop/error pulses that the
//   sniffer controller consumes.
//
//   Build option: define RX_STATS_EN to enable the saturating drop counter.
//   When it is undefined, drop_count is tied to 0.
//
// Ports
//   clk, n_rst    clock, asynchronous active-low reset
//   st_valid      MAC beat valid
//   st_data       MAC beat data
//   st_sop        first beat of packet
//   st_eop        last beat of packet
//   st_error      MAC error flag for this beat
//   st_empty      unused bytes in the eop beat
//   st_ready      beat accept; a beat is taken when st_valid & st_ready
//   fifo_wrfull   input FIFO full
//   fifo_wrreq    input FIFO write strobe
//   fifo_data     input FIFO write data
//   pkt_ready     pulse: new packet started
//   pkt_eop       pulse: packet ended
//   pkt_error     pulse: packet bad
//   pkt_len       byte count of the last good packet, valid from pkt_eop
//   drop_count    saturating count of dropped packets
//
// Handshake: a beat transfers on every rising clk edge where st_valid and
// st_ready are both 1. st_ready does not depend on st_valid. fifo_wrreq is
// asserted only in a transfer cycle, and never while fifo_wrfull is high.
module rx_stream_loader #(
  parameter int DATA_W    = 32,
  parameter int LEN_W     = 12,
  parameter int MAX_BYTES = 1518
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              st_valid,
  input  logic [DATA_W-1:0] st_data,
  input  logic              st_sop,
  input  logic              st_eop,
  input  logic              st_error,
  input  logic [1:0]        st_empty,
  output logic              st_ready,
  input  logic              fifo_wrfull,
  output logic              fifo_wrreq,
  output logic [DATA_W-1:0] fifo_data,
  output logic              pkt_ready,
  output logic              pkt_eop,
  output logic              pkt_error,
  output logic [LEN_W-1:0]  pkt_len,
  output logic [15:0]       drop_count
);

  localparam int BEAT_BYTES = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [LEN_W:0] len, len_nxt;
  logic [1:0]     gap, gap_nxt;
  logic           ready_nxt, eop_nxt, err_nxt, defer_nxt, len_ld;
  logic           eop_pend;
  logic           accept, wr;
  logic [LEN_W:0] beat_bytes, sum;
  logic           oversize, bad;

  // While gap cycles run, input is held off so that the pulses of the next
  // packet cannot land on the eop/error pulses of the previous one.
  assign st_ready = (gap != 2'd0) ? 1'b0 :
                    (state == DROP) ? 1'b1 : !fifo_wrfull;
  assign accept   = st_valid & st_ready;

  assign beat_bytes = st_eop ? ((LEN_W+1)'(BEAT_BYTES) - {{(LEN_W-1){1'b0}}, st_empty})
                             : (LEN_W+1)'(BEAT_BYTES);
  assign sum      = len + beat_bytes;
  // The oversize check uses the length including this beat, so an
  // overflowing beat is never written.
  assign oversize = sum > (LEN_W+1)'(MAX_BYTES);
  assign bad      = st_error | st_sop | oversize;

  assign fifo_wrreq = wr;
  assign fifo_data  = st_data;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      len       <= '0;
      gap       <= 2'd0;
      pkt_ready <= 1'b0;
      pkt_eop   <= 1'b0;
      pkt_error <= 1'b0;
      eop_pend  <= 1'b0;
      pkt_len   <= '0;
    end else begin
      state     <= state_nxt;
      len       <= len_nxt;
      gap       <= gap_nxt;
      pkt_ready <= ready_nxt;
      pkt_error <= err_nxt;
      // A deferred eop is held for one cycle so that it follows pkt_ready
      // or pkt_error instead of coinciding with it.
      eop_pend  <= defer_nxt;
      pkt_eop   <= eop_nxt | eop_pend;
      if (len_ld) pkt_len <= len_nxt[LEN_W-1:0];
    end
  end

  always_comb begin
    state_nxt = state;
    len_nxt   = len;
    gap_nxt   = (gap != 2'd0) ? gap - 2'd1 : gap;
    wr        = 1'b0;
    ready_nxt = 1'b0;
    eop_nxt   = 1'b0;
    err_nxt   = 1'b0;
    defer_nxt = 1'b0;
    len_ld    = 1'b0;
    case (state)
      IDLE: begin
        // Beats without sop are accepted and discarded.
        if (accept && st_sop) begin
          wr        = 1'b1;
          ready_nxt = 1'b1;
          len_nxt   = beat_bytes;
          if (st_eop) begin
            defer_nxt = 1'b1;
            len_ld    = 1'b1;
            gap_nxt   = 2'd2;
          end else begin
            state_nxt = RECV;
          end
        end
      end
      RECV: begin
        if (accept) begin
          if (bad) begin
            err_nxt = 1'b1;
            if (st_eop) begin
              defer_nxt = 1'b1;
              gap_nxt   = 2'd2;
              state_nxt = IDLE;
            end else begin
              state_nxt = DROP;
            end
          end else begin
            wr      = 1'b1;
            len_nxt = sum;
            if (st_eop) begin
              eop_nxt   = 1'b1;
              len_ld    = 1'b1;
              gap_nxt   = 2'd1;
              state_nxt = IDLE;
            end
          end
        end
      end
      DROP: begin
        if (accept && st_eop) begin
          eop_nxt   = 1'b1;
          gap_nxt   = 2'd1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef RX_STATS_EN
  logic [15:0] drop_q;

  // Every pkt_error marks exactly one dropped packet.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      drop_q <= 16'd0;
    end else if (err_nxt && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_rx_stream_loader.sv
// tb_rx_stream_loader
//   Directed bench for rx_stream_loader. It uses a table of per-cycle vectors
//   (inputs plus expected outputs). After the table come hand-written
//   sequences for the oversize packet, sop mid-packet and reset mid-packet.
//   Inputs change on the falling edge. Outputs are sampled 1 ns later, so the
//   combinational write path shows the current beat and the registered
//   pulses show the beat accepted on the previous rising edge.
module tb_rx_stream_loader;

  localparam bit STATS =
`ifdef RX_STATS_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk;
  logic        n_rst;
  logic        st_valid;
  logic [31:0] st_data;
  logic        st_sop, st_eop, st_error;
  logic [1:0]  st_empty;
  logic        st_ready;
  logic        fifo_wrfull;
  logic        fifo_wrreq;
  logic [31:0] fifo_data;
  logic        pkt_ready, pkt_eop, pkt_error;
  logic [11:0] pkt_len;
  logic [15:0] drop_count;

  int total = 0;
  int bad   = 0;

  rx_stream_loader #(.DATA_W(32), .LEN_W(12), .MAX_BYTES(1518)) dut (
    .clk(clk), .n_rst(n_rst),
    .st_valid(st_valid), .st_data(st_data), .st_sop(st_sop), .st_eop(st_eop),
    .st_error(st_error), .st_empty(st_empty), .st_ready(st_ready),
    .fifo_wrfull(fifo_wrfull), .fifo_wrreq(fifo_wrreq), .fifo_data(fifo_data),
    .pkt_ready(pkt_ready), .pkt_eop(pkt_eop), .pkt_error(pkt_error),
    .pkt_len(pkt_len), .drop_count(drop_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v, sop, eop, err;
    logic [1:0]  emp;
    logic        full;
    logic [31:0] data;
    logic        e_rdy, e_wr, e_prdy, e_peop, e_perr;
    int          e_len;   // -1: not checked
    int          e_drop;  // -1: not checked
  } vec_t;

  vec_t tbl[$];

  function automatic int dx(input int n);
    return STATS ? n : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic sop, input logic eop, input logic err,
                     input logic [1:0] emp, input logic full, input logic [31:0] d,
                     input logic rdy, input logic wr, input logic pr, input logic pe,
                     input logic per, input int len, input int drp);
    vec_t r;
    r.v = v; r.sop = sop; r.eop = eop; r.err = err; r.emp = emp; r.full = full;
    r.data = d; r.e_rdy = rdy; r.e_wr = wr; r.e_prdy = pr; r.e_peop = pe;
    r.e_perr = per; r.e_len = len; r.e_drop = drp;
    tbl.push_back(r);
  endtask

  // Driver: present one cycle of inputs on the falling edge, then settle.
  task automatic drive(input logic v, input logic sop, input logic eop, input logic err,
                       input logic [1:0] emp, input logic full, input logic [31:0] d);
    @(negedge clk);
    st_valid = v; st_sop = sop; st_eop = eop; st_error = err;
    st_empty = emp; fifo_wrfull = full; st_data = d;
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0);
  endtask

  int wr_cnt;
  int err_seen;

  initial begin
    n_rst = 1'b0;
    st_valid = 1'b0; st_data = '0; st_sop = 1'b0; st_eop = 1'b0;
    st_error = 1'b0; st_empty = 2'd0; fifo_wrfull = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset pkt_ready", 32'(pkt_ready), 32'd0);
    chk("reset pkt_eop", 32'(pkt_eop), 32'd0);
    chk("reset pkt_error", 32'(pkt_error), 32'd0);
    chk("reset pkt_len", 32'(pkt_len), 32'd0);
    chk("reset drop_count", 32'(drop_count), 32'd0);
    chk("reset fifo_wrreq", 32'(fifo_wrreq), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;

    //   v  s  e  er emp f  data           rdy wr pr pe per len drop
    // 3 beats, empty=2 on last -> 10 bytes
    add(1, 1, 0, 0, 0, 0, 32'hA000_0001, 1, 1, 0, 0, 0, -1, -1);
    add(1, 0, 0, 0, 0, 0, 32'hA000_0002, 1, 1, 1, 0, 0, -1, -1);
    add(1, 0, 1, 0, 2, 0, 32'hA000_0003, 1, 1, 0, 0, 0, -1, -1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 0, 10, -1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, -1, 0);
    // single sop+eop beat, eop deferred, two gap cycles
    add(1, 1, 1, 0, 0, 0, 32'hB000_0001, 1, 1, 0, 0, 0, -1, -1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 1, 0, 0, -1, -1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 0, 4, -1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, -1, -1);
    // 5 beats, error on beat 2
    add(1, 1, 0, 0, 0, 0, 32'hC000_0001, 1, 1, 0, 0, 0, -1, -1);
    add(1, 0, 0, 1, 0, 0, 32'hC000_0002, 1, 0, 1, 0, 0, -1, -1);
    add(1, 0, 0, 0, 0, 0, 32'hC000_0003, 1, 0, 0, 0, 1, -1, dx(1));
    add(1, 0, 0, 0, 0, 0, 32'hC000_0004, 1, 0, 0, 0, 0, -1, -1);
    add(1, 0, 1, 0, 0, 0, 32'hC000_0005, 1, 0, 0, 0, 0, -1, -1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 0, -1, dx(1));
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, -1, -1);
    // fifo full 3 cycles mid-packet, 4+4+3 bytes
    add(1, 1, 0, 0, 0, 0, 32'hD000_0001, 1, 1, 0, 0, 0, -1, -1);
    add(1, 0, 0, 0, 0, 1, 32'hD000_0002, 0, 0, 1, 0, 0, -1, -1);
    add(1, 0, 0, 0, 0, 1, 32'hD000_0002, 0, 0, 0, 0, 0, -1, -1);
    add(1, 0, 0, 0, 0, 1, 32'hD000_0002, 0, 0, 0, 0, 0, -1, -1);
    add(1, 0, 0, 0, 0, 0, 32'hD000_0002, 1, 1, 0, 0, 0, -1, -1);
    add(1, 0, 1, 0, 1, 0, 32'hD000_0003, 1, 1, 0, 0, 0, -1, -1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 0, 11, -1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, -1, -1);
    // non-sop beat in IDLE is discarded
    add(1, 0, 0, 0, 0, 0, 32'hE000_0001, 1, 0, 0, 0, 0, -1, -1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, -1, -1);
    // error on eop beat: pkt_error then deferred pkt_eop, two gap cycles
    add(1, 1, 0, 0, 0, 0, 32'hF000_0001, 1, 1, 0, 0, 0, -1, -1);
    add(1, 0, 1, 1, 0, 0, 32'hF000_0002, 1, 0, 1, 0, 0, -1, -1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 1, -1, dx(2));
    add(0, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 1, 0, 11, -1);
    add(0, 0, 0, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, -1, dx(2));

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].sop, tbl[i].eop, tbl[i].err, tbl[i].emp, tbl[i].full, tbl[i].data);
      chk($sformatf("row%0d st_ready", i), 32'(st_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d fifo_wrreq", i), 32'(fifo_wrreq), 32'(tbl[i].e_wr));
      chk($sformatf("row%0d pkt_ready", i), 32'(pkt_ready), 32'(tbl[i].e_prdy));
      chk($sformatf("row%0d pkt_eop", i), 32'(pkt_eop), 32'(tbl[i].e_peop));
      chk($sformatf("row%0d pkt_error", i), 32'(pkt_error), 32'(tbl[i].e_perr));
      if (tbl[i].e_wr)
        chk($sformatf("row%0d fifo_data", i), fifo_data, tbl[i].data);
      if (tbl[i].e_len >= 0)
        chk($sformatf("row%0d pkt_len", i), 32'(pkt_len), 32'(tbl[i].e_len));
      if (tbl[i].e_drop >= 0)
        chk($sformatf("row%0d drop_count", i), 32'(drop_count), 32'(tbl[i].e_drop));
    end

    // Oversize: 380 full beats; beat 380 would reach 1520 bytes
    wr_cnt = 0;
    err_seen = 0;
    for (int b = 1; b <= 379; b++) begin
      drive(1'b1, (b == 1), 1'b0, 1'b0, 2'd0, 1'b0, 32'h1000_0000 + 32'(b));
      if (fifo_wrreq && fifo_data == 32'h1000_0000 + 32'(b)) wr_cnt++;
      if (pkt_error) err_seen++;
    end
    chk("oversize writes before limit", 32'(wr_cnt), 32'd379);
    chk("oversize early pkt_error", 32'(err_seen), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h1000_017C);
    chk("oversize beat380 wrreq", 32'(fifo_wrreq), 32'd0);
    chk("oversize beat380 st_ready", 32'(st_ready), 32'd1);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 32'h1000_017D);
    chk("oversize pkt_error", 32'(pkt_error), 32'd1);
    chk("oversize drop wrreq", 32'(fifo_wrreq), 32'd0);
    chk("oversize drop_count", 32'(drop_count), 32'(dx(3)));
    idle_cycle();
    chk("oversize pkt_eop", 32'(pkt_eop), 32'd1);
    chk("oversize gap st_ready", 32'(st_ready), 32'd0);
    idle_cycle();

    // sop mid-packet drops the packet
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h2000_0001);
    chk("midsop beat1 wrreq", 32'(fifo_wrreq), 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h2000_0002);
    chk("midsop beat2 wrreq", 32'(fifo_wrreq), 32'd1);
    chk("midsop pkt_ready", 32'(pkt_ready), 32'd1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h2000_0003);
    chk("midsop sop beat wrreq", 32'(fifo_wrreq), 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h2000_0004);
    chk("midsop pkt_error", 32'(pkt_error), 32'd1);
    chk("midsop drop_count", 32'(drop_count), 32'(dx(4)));

    // Reset mid-packet (in DROP): everything clears, IDLE
    @(negedge clk);
    n_rst = 1'b0;
    st_sop = 1'b0; st_eop = 1'b0;
    #1;
    chk("midrst pkt_ready", 32'(pkt_ready), 32'd0);
    chk("midrst pkt_eop", 32'(pkt_eop), 32'd0);
    chk("midrst pkt_error", 32'(pkt_error), 32'd0);
    chk("midrst pkt_len", 32'(pkt_len), 32'd0);
    chk("midrst drop_count", 32'(drop_count), 32'd0);
    chk("midrst fifo_wrreq", 32'(fifo_wrreq), 32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h3000_0001);
    chk("postrst non-sop wrreq", 32'(fifo_wrreq), 32'd0);
    idle_cycle();
    chk("postrst no pkt_ready", 32'(pkt_ready), 32'd0);
    chk("postrst no pkt_eop", 32'(pkt_eop), 32'd0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 32'h3000_0002);
    chk("postrst sop wrreq", 32'(fifo_wrreq), 32'd1);
    idle_cycle();
    chk("postrst pkt_ready", 32'(pkt_ready), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
